// File: rtl/goldschmidt_ctrl_if.sv
// Control bundle between the Goldschmidt sequencer and its requester/datapath.
interface goldschmidt_ctrl_if #(
  parameter int unsigned IW = 3
);

  logic          start;
  logic [IW-1:0] iter_cnt;
  logic          busy;
  logic          done;
  logic [1:0]    sel_ND_mux;
  logic          sel_K_mux;
  logic          load_regN;
  logic          load_regD;
  logic [2:0]    step;

  // Requester side: issues start and iteration count, observes control.
  modport master (
    output start,
    output iter_cnt,
    input  busy,
    input  done,
    input  sel_ND_mux,
    input  sel_K_mux,
    input  load_regN,
    input  load_regD,
    input  step
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  iter_cnt,
    output busy,
    output done,
    output sel_ND_mux,
    output sel_K_mux,
    output load_regN,
    output load_regD,
    output step
  );

endinterface

// File: rtl/goldschmidt_ctrl.sv
// Sequencing FSM for the Goldschmidt divider datapath: one scaling pass
// (N*IA, D*IA) followed by a programmable number of refinement iterations
// (regN*K, regD*K), each multiply step held MUL_LAT cycles.
module goldschmidt_ctrl #(
  parameter int unsigned MUL_LAT  = 1,
  parameter int unsigned MAX_ITER = 7,
  parameter int unsigned IW       = 3
) (
  input  logic              clk,
  input  logic              reset,
  goldschmidt_ctrl_if.slave bus
);

  localparam int unsigned SW = 3;
  localparam int unsigned HW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [SW-1:0] S_IDLE   = 3'b000;
  localparam logic [SW-1:0] S_INIT_N = 3'b001;
  localparam logic [SW-1:0] S_INIT_D = 3'b010;
  localparam logic [SW-1:0] S_ITER_N = 3'b011;
  localparam logic [SW-1:0] S_ITER_D = 3'b100;
  localparam logic [SW-1:0] S_DONE   = 3'b101;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MUL_LAT - 1);
  localparam logic [IW-1:0] ITER_MIN  = IW'(1);
  localparam logic [IW-1:0] ITER_MAX  = IW'(MAX_ITER);

  localparam logic [1:0] SEL_N    = 2'b00;
  localparam logic [1:0] SEL_D    = 2'b01;
  localparam logic [1:0] SEL_RN   = 2'b10;
  localparam logic [1:0] SEL_RD   = 2'b11;

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_nxt;
  logic [IW-1:0] iter_rem;
  logic [IW-1:0] iter_rem_nxt;
  logic [IW-1:0] iter_eff;
  logic          step_last;

  logic          busy_nxt;
  logic          done_nxt;
  logic [1:0]    sel_nd_nxt;
  logic          sel_k_nxt;
  logic          load_n_nxt;
  logic          load_d_nxt;
  logic          load_slot_nxt;

  assign step_last = (hold == HOLD_LAST);

  // Effective iteration count: zero behaves as one, large values clamp.
  always_comb begin
    iter_eff = bus.iter_cnt;
    if (bus.iter_cnt == '0) begin
      iter_eff = ITER_MIN;
    end else if (bus.iter_cnt > ITER_MAX) begin
      iter_eff = ITER_MAX;
    end
  end

  // Next state, hold/iteration counters, and next-cycle control outputs.
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    iter_rem_nxt  = iter_rem;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    sel_nd_nxt    = SEL_N;
    sel_k_nxt     = 1'b0;
    load_n_nxt    = 1'b0;
    load_d_nxt    = 1'b0;
    load_slot_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt    = S_INIT_N;
          hold_nxt     = '0;
          iter_rem_nxt = iter_eff;
        end
      end
      S_INIT_N: begin
        if (step_last) begin
          state_nxt = S_INIT_D;
          hold_nxt  = '0;
        end else begin
          hold_nxt  = hold + HW'(1);
        end
      end
      S_INIT_D: begin
        if (step_last) begin
          state_nxt = S_ITER_N;
          hold_nxt  = '0;
        end else begin
          hold_nxt  = hold + HW'(1);
        end
      end
      S_ITER_N: begin
        if (step_last) begin
          state_nxt = S_ITER_D;
          hold_nxt  = '0;
        end else begin
          hold_nxt  = hold + HW'(1);
        end
      end
      S_ITER_D: begin
        if (step_last) begin
          hold_nxt     = '0;
          iter_rem_nxt = iter_rem - IW'(1);
          state_nxt    = (iter_rem > ITER_MIN) ? S_ITER_N : S_DONE;
        end else begin
          hold_nxt     = hold + HW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt    = S_IDLE;
        hold_nxt     = '0;
        iter_rem_nxt = '0;
      end
    endcase

    // Loads fire only in the final hold cycle of the upcoming step.
    load_slot_nxt = (hold_nxt == HOLD_LAST);

    case (state_nxt)
      S_INIT_N: begin
        busy_nxt   = 1'b1;
        sel_nd_nxt = SEL_N;
        load_n_nxt = load_slot_nxt;
      end
      S_INIT_D: begin
        busy_nxt   = 1'b1;
        sel_nd_nxt = SEL_D;
        load_d_nxt = load_slot_nxt;
      end
      S_ITER_N: begin
        busy_nxt   = 1'b1;
        sel_nd_nxt = SEL_RN;
        sel_k_nxt  = 1'b1;
        load_n_nxt = load_slot_nxt;
      end
      S_ITER_D: begin
        busy_nxt   = 1'b1;
        sel_nd_nxt = SEL_RD;
        sel_k_nxt  = 1'b1;
        load_d_nxt = load_slot_nxt;
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      hold     <= '0;
      iter_rem <= '0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      iter_rem <= iter_rem_nxt;
    end
  end

  // Registered control outputs, aligned with the state they decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.sel_ND_mux <= SEL_N;
      bus.sel_K_mux  <= 1'b0;
      bus.load_regN  <= 1'b0;
      bus.load_regD  <= 1'b0;
      bus.step       <= S_IDLE;
    end else begin
      bus.busy       <= busy_nxt;
      bus.done       <= done_nxt;
      bus.sel_ND_mux <= sel_nd_nxt;
      bus.sel_K_mux  <= sel_k_nxt;
      bus.load_regN  <= load_n_nxt;
      bus.load_regD  <= load_d_nxt;
      bus.step       <= state_nxt;
    end
  end

endmodule

// File: doc/goldschmidt_ctrl.md
Name: goldschmidt_ctrl

Overview:
- Sequencing FSM for the Goldschmidt divider datapath: drives sel_ND_mux, sel_K_mux, load_regN and load_regD so the datapath computes N/D from operands and the initial approximation IA.
- Accepts a start pulse and runs one initial scaling pass followed by a programmable number of refinement iterations, then signals done.
- Sits beside the datapath. Operands and IA go straight to the datapath; this block handles control only.

Parameters:
- MUL_LAT, 1, cycles each multiply step is held before its load (multiplier latency, ≥1).
- MAX_ITER, 7, upper bound on refinement iterations.
- IW, 3, width of iter_cnt; must satisfy 2**IW-1 ≥ MAX_ITER.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- iter_cnt  input  IW  number of refinement iterations; latched when start is accepted.
- busy  output  1  high while a division sequence is in progress.
- done  output  1  one-cycle pulse; datapath result is valid during this cycle.
- sel_ND_mux  output  2  00 = N operand, 01 = D operand, 10 = regN feedback, 11 = regD feedback.
- sel_K_mux  output  1  0 = IA, 1 = K (two's complement of regD, i.e. 2−D).
- load_regN  output  1  capture multiplier output into regN at next edge.
- load_regD  output  1  capture multiplier output into regD at next edge.
- step  output  3  current state encoding, for debug/observation.

Behaviour:
- Reset (reset=0, async): state=IDLE, hold counter=0, iteration counter=0.
  - Outputs: busy=0, done=0, sel_ND_mux=00, sel_K_mux=0, load_regN=0, load_regD=0, step=000.
- Registered state; all outputs decoded from state (Moore). No output depends combinationally on start.
- States (step code) and their control outputs:
  - IDLE (000): sel_ND_mux=00, sel_K_mux=0, no loads, busy=0.
  - INIT_N (001): sel_ND_mux=00, sel_K_mux=0; computes N·IA.
  - INIT_D (010): sel_ND_mux=01, sel_K_mux=0; computes D·IA.
  - ITER_N (011): sel_ND_mux=10, sel_K_mux=1; computes regN·K.
  - ITER_D (100): sel_ND_mux=11, sel_K_mux=1; computes regD·K.
  - DONE (101): sel_ND_mux=00, sel_K_mux=0, no loads, done=1, busy=0.
- Step hold: each of INIT_N, INIT_D, ITER_N and ITER_D lasts exactly MUL_LAT cycles.
  - The hold counter resets to 0 on entry to each step.
  - Mux selects are stable for the whole step.
  - The load for that step is asserted only in the final cycle of the step: load_regN in INIT_N/ITER_N, load_regD in INIT_D/ITER_D. Never both at once.
- Transitions:
  - IDLE→INIT_N when start=1 at a clock edge. The effective iteration count is latched at that edge:
    - iter_cnt=0 is treated as 1;
    - iter_cnt>MAX_ITER is clamped to MAX_ITER.
  - INIT_N→INIT_D→ITER_N after their holds.
  - ITER_N→ITER_D after its hold.
  - ITER_D→ITER_N if iterations remain, else →DONE. The iteration counter decrements on leaving ITER_D.
  - DONE→IDLE unconditionally after 1 cycle.
- busy=1 in INIT_N through ITER_D inclusive.
- Total cycles from the start-accept edge to the done cycle: (2+2·iters)·MUL_LAT, with done in the cycle after that.
- start is ignored when not in IDLE; this includes during DONE. start held high continuously launches back-to-back divisions with exactly one IDLE cycle between them.
- Changes to iter_cnt after the start-accept edge have no effect.
- reset asserted mid-sequence: immediate return to IDLE with reset outputs. No done pulse is produced, and a partial datapath result is abandoned.

Test Plan:
- Reset check: assert reset=0 mid-ITER_N with MUL_LAT=1 → all outputs go to reset values asynchronously; step=000; no done pulse after release.
- Basic sequence, MUL_LAT=1, iter_cnt=1, start pulsed one cycle:
  - cycle 1: 00/0, load_regN;
  - cycle 2: 01/0, load_regD;
  - cycle 3: 10/1, load_regN;
  - cycle 4: 11/1, load_regD;
  - cycle 5: done=1;
  - busy high in cycles 1–4.
- MUL_LAT=3, iter_cnt=2 → each step's selects are held 3 cycles with its load only on the 3rd cycle; 18 busy cycles; done in cycle 19; exactly 3 load_regN and 3 load_regD pulses.
- Boundary counts:
  - iter_cnt=0 → identical to iter_cnt=1 (4 busy cycles at MUL_LAT=1);
  - iter_cnt=7 with MAX_ITER=3 → 3 iterations (8 busy cycles).
- Start while busy or in DONE: pulse start in cycles 2 and 5 of an iter_cnt=1 run → ignored; step returns to 000 after done. Holding start high → next INIT_N begins 2 cycles after done.
- iter_cnt changed from 1 to 5 in cycle 2 → the run still performs exactly 1 iteration.
